// File: rtl/fadd_result_wb.sv
// Writeback stage behind the FP32 lane adder: 2-entry skid FIFO, lane/VGPR tagging,
// sticky exception status and per-instruction done. Option: FADD_WB_CANON_NAN_EN.
module fadd_result_wb #(
    parameter int DATA_W = 32,
    parameter int LANES  = 32,
    parameter int VGPR_W = 8,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_nan,
    input  logic              in_ovf,
    input  logic [VGPR_W-1:0] in_vdst,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic [LW-1:0]     wr_lane,
    output logic [VGPR_W-1:0] wr_vgpr,
    output logic              sts_nan,
    output logic              sts_ovf,
    input  logic              sts_clr,
    output logic              done,
    output logic              instr_exc
);
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LW-1:0]     lane;
        logic [VGPR_W-1:0] vgpr;
        logic              nan;
        logic              ovf;
    } entry_t;

    typedef enum logic {IDLE, RUN} state_t;

    entry_t            mem [2];
    entry_t            head;
    logic              wp, rp;
    logic [1:0]        count;
    logic [LW-1:0]     in_lane;
    logic [VGPR_W-1:0] vdst_q;
    logic              push, pop, head_flag;
    state_t            state;
    logic              instr_acc;

    assign in_ready  = (count != 2'd2);
    assign wr_valid  = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = wr_valid && wr_ready;
    assign head      = mem[rp];
    assign head_flag = head.nan | head.ovf;
    assign wr_lane   = head.lane;
    assign wr_vgpr   = head.vgpr;
`ifdef FADD_WB_CANON_NAN_EN
    assign wr_data   = head.nan ? DATA_W'(32'h7FC0_0000) : head.data;
`else
    assign wr_data   = head.data;
`endif

    // FIFO storage, pointers and input tagging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            count   <= 2'd0;
            in_lane <= '0;
            vdst_q  <= '0;
        end else begin
            if (push) begin
                mem[wp] <= '{data: in_data, lane: in_lane,
                             vgpr: (in_lane == '0) ? in_vdst : vdst_q,
                             nan: in_nan, ovf: in_ovf};
                wp      <= ~wp;
                in_lane <= (in_lane == LAST) ? '0 : in_lane + 1'b1;
                if (in_lane == '0) vdst_q <= in_vdst;
            end
            if (pop) rp <= ~rp;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Output FSM: tracks one instruction's write-out and raises done after its last lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            instr_acc <= 1'b0;
            done      <= 1'b0;
            instr_exc <= 1'b0;
        end else begin
            done      <= 1'b0;
            instr_exc <= 1'b0;
            if (pop) begin
                case (state)
                    IDLE: if (head.lane == '0) begin
                        if (LANES == 1) begin
                            done      <= 1'b1;
                            instr_exc <= head_flag;
                        end else begin
                            state     <= RUN;
                            instr_acc <= head_flag;
                        end
                    end
                    RUN: if (head.lane == LAST) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        instr_exc <= instr_acc | head_flag;
                    end else begin
                        instr_acc <= instr_acc | head_flag;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Sticky status; a flagged pop overrides a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_nan <= 1'b0;
            sts_ovf <= 1'b0;
        end else begin
            sts_nan <= (sts_nan & ~sts_clr) | (pop & head.nan);
            sts_ovf <= (sts_ovf & ~sts_clr) | (pop & head.ovf);
        end
    end
endmodule

// File: tb/tb_fadd_result_wb.sv
// Scoreboard bench for fadd_result_wb: driver pushes expected beats, negedge monitor checks.
module tb_fadd_result_wb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_data = '0;
    logic        in_nan = 1'b0, in_ovf = 1'b0;
    logic [7:0]  in_vdst = '0;
    logic        wr_valid, wr_ready = 1'b0;
    logic [31:0] wr_data;
    logic [4:0]  wr_lane;
    logic [7:0]  wr_vgpr;
    logic        sts_nan, sts_ovf, sts_clr = 1'b0, done, instr_exc;

    fadd_result_wb #(.DATA_W(32), .LANES(32), .VGPR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_nan(in_nan), .in_ovf(in_ovf), .in_vdst(in_vdst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_lane(wr_lane), .wr_vgpr(wr_vgpr), .sts_nan(sts_nan), .sts_ovf(sts_ovf),
        .sts_clr(sts_clr), .done(done), .instr_exc(instr_exc));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  lane;
        logic [7:0]  vgpr;
        logic        nan;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, last_done = 0, prev_done = 0;
    logic exp_nan = 0, exp_ovf = 0, exp_done = 0, exp_exc = 0, acc_flag = 0;
    logic [4:0] m_lane = '0;
    logic [7:0] m_vdst = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] exp_data(logic [31:0] d, logic n);
`ifdef FADD_WB_CANON_NAN_EN
        return n ? 32'h7FC0_0000 : d;
`else
        return d;
`endif
    endfunction

    // Monitor: queue occupancy is the reference FIFO; instruction and sticky state from popped beats
    always @(negedge clk) begin
        exp_t e;
        logic nd, ne;
        cyc++;
        if (!rst_n) begin
            q.delete();
            exp_nan = 0; exp_ovf = 0; exp_done = 0; exp_exc = 0; acc_flag = 0;
        end else begin
            chk("in_ready", in_ready, q.size() != 2);
            chk("wr_valid", wr_valid, q.size() != 0);
            chk("done", done, exp_done);
            if (exp_done) chk("instr_exc", instr_exc, exp_exc);
            if (done) begin prev_done = last_done; last_done = cyc; end
            chk("sts_nan", sts_nan, exp_nan);
            chk("sts_ovf", sts_ovf, exp_ovf);
            nd = 0; ne = 0;
            if (sts_clr) begin exp_nan = 0; exp_ovf = 0; end
            if (wr_valid && wr_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("wr_data", wr_data, e.data);
                chk("wr_lane", {27'd0, wr_lane}, {27'd0, e.lane});
                chk("wr_vgpr", {24'd0, wr_vgpr}, {24'd0, e.vgpr});
                exp_nan = exp_nan | e.nan;
                exp_ovf = exp_ovf | e.ovf;
                if (e.lane == 0) acc_flag = 0;
                acc_flag = acc_flag | e.nan | e.ovf;
                if (e.lane == 5'd31) begin nd = 1; ne = acc_flag; end
            end
            exp_done = nd; exp_exc = ne;
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic n, input logic o,
                        input logic [7:0] vd, input logic rdy, input logic clr, output logic acc);
        exp_t e;
        @(posedge clk); #1;
        in_valid = v; in_data = d; in_nan = n; in_ovf = o; in_vdst = vd;
        wr_ready = rdy; sts_clr = clr;
        @(negedge clk); #1;
        acc = v && in_ready && rst_n;
        if (acc) begin
            e.data = exp_data(d, n);
            e.lane = m_lane;
            e.vgpr = (m_lane == 0) ? vd : m_vdst;
            e.nan  = n;
            e.ovf  = o;
            if (m_lane == 0) m_vdst = vd;
            q.push_back(e);
            m_lane = m_lane + 5'd1;
        end
    endtask

    task automatic idle(input int n, input logic clr);
        logic a;
        for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 8'd0, 1, clr, a);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 50 && q.size() != 0; i++) step(0, 32'd0, 0, 0, 8'd0, 1, 0, a);
        chk("drain_empty", q.size(), 0);
        idle(3, 0);
    endtask

    // Non-lane-0 beats carry random vdst so the lane-0 latch is exercised
    task automatic stream(input int nb, input logic [7:0] vd, input int pv, input int pr,
                          input int pf, input int pc, input int nan_lane, input bit seq);
        int sent = 0, guard = 0;
        logic v, r, c, n, o, a;
        logic [31:0] d;
        logic [7:0] vx;
        while (sent < nb) begin
            if (guard++ > 2000) begin chk("stream_timeout", 1, 0); break; end
            v  = ($urandom_range(99) < pv);
            r  = ($urandom_range(99) < pr);
            c  = ($urandom_range(99) < pc);
            n  = (int'(m_lane) == nan_lane) || ($urandom_range(99) < pf);
            o  = ($urandom_range(99) < pf);
            d  = seq ? 32'(sent) : $urandom;
            if (int'(m_lane) == nan_lane) d = 32'h7FFF_FFFF;
            vx = (m_lane == 0) ? vd : 8'($urandom);
            step(v, d, n, o, vx, r, c, a);
            if (a) sent++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic a;
        repeat (2) @(negedge clk);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_sts_nan", sts_nan, 0);
        chk("rst_sts_ovf", sts_ovf, 0);
        chk("rst_done", done, 0);
        chk("rst_instr_exc", instr_exc, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_lane", {27'd0, wr_lane}, 0);
        chk("rst_wr_vgpr", {24'd0, wr_vgpr}, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // streaming, data=i, vdst=5
        stream(32, 8'd5, 100, 100, 0, 0, -1, 1);
        drain();

        // backpressure: fill both slots, then release with random readiness
        for (int i = 0; i < 4; i++) step(1, 32'(100 + i), 0, 0, 8'd6, 0, 0, a);
        chk("bp_full_ready", in_ready, 0);
        stream(30, 8'd6, 100, 50, 0, 0, -1, 1);
        drain();

        // NaN on lane 7
        stream(32, 8'd7, 100, 100, 0, 0, 7, 1);
        drain();
        chk("exc_sts_nan_held", sts_nan, 1);
        idle(1, 1);
        idle(1, 0);
        chk("exc_sts_nan_clr", sts_nan, 0);

        // clear colliding with an overflow pop
        step(1, 32'h1234, 0, 1, 8'd2, 1, 0, a);
        step(0, 32'd0, 0, 0, 8'd0, 1, 1, a);
        step(0, 32'd0, 0, 0, 8'd0, 1, 1, a);
        chk("collision_ovf_wins", sts_ovf, 1);
        step(0, 32'd0, 0, 0, 8'd0, 1, 0, a);
        chk("collision_clr_alone", sts_ovf, 0);
        stream(31, 8'd2, 100, 100, 0, 0, -1, 1);
        drain();

        // back-to-back instructions
        stream(32, 8'd5, 100, 100, 0, 0, -1, 1);
        stream(32, 8'd9, 100, 100, 0, 0, -1, 1);
        drain();
        chk("b2b_done_gap", last_done - prev_done, 32);

        // randomized traffic
        for (int k = 0; k < 6; k++) begin
            stream(32, 8'($urandom), 70, 70, 8, 10, -1, 0);
            drain();
        end

        // reset with one entry buffered mid-instruction
        step(1, 32'h55, 0, 1, 8'd3, 1, 0, a);
        step(1, 32'h56, 0, 0, 8'd3, 1, 0, a);
        step(0, 32'd0, 0, 0, 8'd0, 0, 0, a);
        chk("mid_buffered", wr_valid, 1);
        chk("mid_sts_ovf_set", sts_ovf, 1);
        @(posedge clk); #1; rst_n = 1'b0; m_lane = '0; m_vdst = '0;
        @(negedge clk);
        chk("mid_rst_wr_valid", wr_valid, 0);
        chk("mid_rst_sts_ovf", sts_ovf, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk); #1; rst_n = 1'b1; wr_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        idle(3, 0);
        stream(32, 8'd11, 80, 80, 5, 5, -1, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
